// File: rtl/axi_key_event_pkg.sv
// Shared constants and the event entry type for the key event register block.
// AXI_KEY_TIMESTAMP_EN: when defined, each event entry also carries a 16-bit
// cycle timestamp captured at push time.
package axi_key_event_pkg;

  // Byte offsets of the four registers
  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_IRQ_EN = 4'h4;
  localparam logic [3:0] OFF_EVENT  = 4'h8;
  localparam logic [3:0] OFF_LEVEL  = 4'hC;

  // Field positions
  localparam int OVF_BIT   = 31;
  localparam int VALID_BIT = 31;
  localparam int TS_LSB    = 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

`ifdef AXI_KEY_TIMESTAMP_EN
  typedef struct packed {
    logic [15:0] ts;
    logic [7:0]  key;
  } event_entry_t;
`else
  typedef struct packed {
    logic [7:0] key;
  } event_entry_t;
`endif

endpackage

// File: rtl/axi_key_event_regs_if.sv
// AXI4-Lite channel bundle for the key event register block.
interface axi_key_event_regs_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_key_event_regs_fifo.sv
// Synchronous first-word-fall-through FIFO holding key events.
// Flush has priority over push and pop; pointers wrap modulo DEPTH.
module key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents are meaningless while empty so no reset needed
  always_ff @(posedge clk) begin
    if (do_push && !flush && !srst) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/axi_key_event_regs.sv
// AXI4-Lite key event register block: sticky W1C status, interrupt mask,
// ordered event FIFO (read-to-pop) and FIFO level/flush register.
// AXI_KEY_TIMESTAMP_EN: adds a free-running 16-bit cycle counter captured
// into EVENT[23:8] when an event is pushed.
module axi_key_event_regs
  import axi_key_event_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int N_KEYS             = 4,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESET,
  axi_key_event_regs_if.slave  s_axi,
  input  logic [N_KEYS-1:0]    pulse_key,
  output logic                 irq
);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  // AXI handshake state
  logic                          awready_reg, wready_reg, bvalid_reg;
  logic                          arready_reg, rvalid_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;
  logic                          wr_fire, rd_fire;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [3:0]                    wr_word, rd_word;
  logic [C_S_AXI_DATA_WIDTH-1:0] wmask, wbits, rd_value;

  // Register state
  logic [N_KEYS-1:0] status_reg, status_next;
  logic              ovf_reg, ovf_next;
  logic [N_KEYS-1:0] irq_en_reg;
  logic [N_KEYS-1:0] pend_reg, pend_next;
  logic              irq_reg;

  // Event path
  logic [N_KEYS-1:0] push_onehot;
  logic              fifo_push, fifo_pop, flush;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  event_entry_t      push_entry, fifo_dout;

`ifdef AXI_KEY_TIMESTAMP_EN
  logic [15:0] ts_reg;
`endif

  assign wr_fire = awready_reg && s_axi.awvalid && s_axi.wvalid;
  assign rd_fire = arready_reg && s_axi.arvalid;
  assign wr_addr = s_axi.awaddr;
  assign rd_addr = s_axi.araddr;
  assign wr_word = {wr_addr[3:2], 2'b00};
  assign rd_word = {rd_addr[3:2], 2'b00};

  // Expand byte strobes into a bit mask
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{s_axi.wstrb[gi]}};
    end
  endgenerate
  assign wbits = s_axi.wdata & wmask;

  assign s_axi.awready = awready_reg;
  assign s_axi.wready  = wready_reg;
  assign s_axi.bvalid  = bvalid_reg;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = arready_reg;
  assign s_axi.rvalid  = rvalid_reg;
  assign s_axi.rdata   = rdata_reg;
  assign s_axi.rresp   = RESP_OKAY;
  assign irq           = irq_reg;

  // Write channel: accept address+data together only when no response is pending
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
    end else begin
      awready_reg <= !awready_reg && s_axi.awvalid && s_axi.wvalid && !bvalid_reg;
      wready_reg  <= !awready_reg && s_axi.awvalid && s_axi.wvalid && !bvalid_reg;
      if (wr_fire)                        bvalid_reg <= 1'b1;
      else if (bvalid_reg && s_axi.bready) bvalid_reg <= 1'b0;
    end
  end

  // Read channel: registered data, one outstanding read at a time
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      arready_reg <= !arready_reg && s_axi.arvalid && !rvalid_reg;
      if (rd_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_value;
      end else if (rvalid_reg && s_axi.rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  // Read mux; an empty EVENT read returns all zeros
  always_comb begin
    rd_value = '0;
    case (rd_word)
      OFF_STATUS: begin
        rd_value[N_KEYS-1:0] = status_reg;
        rd_value[OVF_BIT]    = ovf_reg;
      end
      OFF_IRQ_EN: rd_value[N_KEYS-1:0] = irq_en_reg;
      OFF_EVENT: begin
        if (!fifo_empty) begin
          rd_value[VALID_BIT] = 1'b1;
          rd_value[7:0]       = fifo_dout.key;
`ifdef AXI_KEY_TIMESTAMP_EN
          rd_value[TS_LSB +: 16] = fifo_dout.ts;
`endif
        end
      end
      OFF_LEVEL: rd_value[15:0] = 16'(fifo_count);
      default: ;
    endcase
  end

  assign flush       = wr_fire && (wr_word == OFF_LEVEL) && s_axi.wdata[0];
  assign fifo_pop    = rd_fire && (rd_word == OFF_EVENT) && !fifo_empty;
  assign fifo_push   = (|pend_reg) && !fifo_full && !flush;
  assign push_onehot = pend_reg & (~pend_reg + N_KEYS'(1));

  // Lowest pending key index forms the next FIFO entry
  always_comb begin
    push_entry = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend_reg[i]) push_entry.key = 8'(i);
    end
`ifdef AXI_KEY_TIMESTAMP_EN
    push_entry.ts = ts_reg;
`endif
  end

  // Sticky status, overflow and pending bits; a pulse beats a same-cycle W1C
  always_comb begin
    status_next = (status_reg & ~((wr_fire && wr_word == OFF_STATUS) ? wbits[N_KEYS-1:0] : '0))
                  | pulse_key;
    ovf_next    = (ovf_reg & ~(wr_fire && wr_word == OFF_STATUS && wbits[OVF_BIT]))
                  | (|(pulse_key & pend_reg));
    if (flush) pend_next = '0;
    else       pend_next = (pend_reg & ~(fifo_push ? push_onehot : '0)) | pulse_key;
  end

  // Register file and interrupt output
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      status_reg <= '0;
      ovf_reg    <= 1'b0;
      irq_en_reg <= '0;
      pend_reg   <= '0;
      irq_reg    <= 1'b0;
    end else begin
      status_reg <= status_next;
      ovf_reg    <= ovf_next;
      pend_reg   <= pend_next;
      if (wr_fire && wr_word == OFF_IRQ_EN)
        irq_en_reg <= (irq_en_reg & ~wmask[N_KEYS-1:0]) | wbits[N_KEYS-1:0];
      irq_reg <= |(status_reg & irq_en_reg);
    end
  end

`ifdef AXI_KEY_TIMESTAMP_EN
  // Free-running cycle counter for event timestamps
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) ts_reg <= '0;
    else              ts_reg <= ts_reg + 16'd1;
  end
`endif

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(event_entry_t))
  ) u_fifo (
    .clk   (S_AXI_ACLK),
    .srst  (S_AXI_ARESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (push_entry),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bits of the bus that carry no meaning for this block
  logic unused_bits;
  assign unused_bits = &{1'b0, s_axi.awprot, s_axi.arprot, wr_addr[1:0], rd_addr[1:0],
                         wbits, wmask, s_axi.wdata};

endmodule

// File: tb/tb_axi_key_event_regs.sv
// Directed self-checking bench for axi_key_event_regs.
module tb_axi_key_event_regs;
  logic       clk;
  logic       rst;
  logic [3:0] pulse_key;
  logic       irq;
  int         total;
  int         bad;

  axi_key_event_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  axi_key_event_regs #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .N_KEYS             (4),
    .FIFO_DEPTH         (8)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (bus),
    .pulse_key    (pulse_key),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic [3:0] keys);
    pulse_key = keys;
    @(posedge clk); #1;
    pulse_key = 4'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    data = 32'h0;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL rd_handshake addr=%h arready never seen", addr);
      bus.arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    if (bus.rvalid !== 1'b1 || bus.rresp !== 2'b00) begin
      bad++;
      $display("FAIL rd_resp addr=%h rvalid=%b rresp=%b want 1/00", addr, bus.rvalid, bus.rresp);
    end
    data = bus.rdata;
    $display("read  addr=%h data=%h", addr, data);
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [3:0] pls);
    int n;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL wr_handshake addr=%h awready never seen", addr);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      return;
    end
    pulse_key = pls;
    @(posedge clk); #1;
    pulse_key = 4'b0;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
      bad++;
      $display("FAIL wr_resp addr=%h bvalid=%b bresp=%b want 1/00", addr, bus.bvalid, bus.bresp);
    end
    $display("write addr=%h data=%h strb=%b", addr, data, strb);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    logic [3:0]  offs [4];
    offs = '{4'h0, 4'h4, 4'h8, 4'hC};
    rst = 1'b1;
    idle(3);
    total++;
    if ({irq, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want 000000",
               {irq, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid});
    end
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      axi_read(offs[i], got);
      total++;
      if (got !== 32'h0) begin
        bad++;
        $display("FAIL reset_read off=%h got=%h want 00000000", offs[i], got);
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] got;
    pulse(4'b0100);
    idle(2);
    axi_read(4'h0, got); total++;
    if (got !== 32'h4) begin bad++; $display("FAIL single_status got=%h want 00000004", got); end
    axi_read(4'hC, got); total++;
    if (got !== 32'h1) begin bad++; $display("FAIL single_level got=%h want 00000001", got); end
    axi_read(4'h8, got); total++;
    if (got !== 32'h8000_0002) begin bad++; $display("FAIL single_event got=%h want 80000002", got); end
    axi_read(4'hC, got); total++;
    if (got !== 32'h0) begin bad++; $display("FAIL single_level_after got=%h want 00000000", got); end
    axi_read(4'h8, got); total++;
    if (got !== 32'h0) begin bad++; $display("FAIL single_empty_event got=%h want 00000000", got); end
    axi_write(4'h0, 32'h8000_000F, 4'hF, 4'b0);
  endtask

  task automatic test_multi();
    logic [31:0] got;
    logic [31:0] exp [3];
    exp = '{32'h8000_0000, 32'h8000_0001, 32'h8000_0003};
    pulse(4'b1011);
    idle(4);
    for (int i = 0; i < 3; i++) begin
      axi_read(4'h8, got); total++;
      if (got !== exp[i]) begin bad++; $display("FAIL multi_event%0d got=%h want %h", i, got, exp[i]); end
    end
    axi_read(4'h0, got); total++;
    if (got !== 32'hB) begin bad++; $display("FAIL multi_status got=%h want 0000000b", got); end
    axi_write(4'h0, 32'h8000_000F, 4'hF, 4'b0);
  endtask

  task automatic test_overflow();
    logic [31:0] got;
    logic [31:0] exp [7];
    exp = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0003, 32'h8000_0000,
            32'h8000_0001, 32'h8000_0002, 32'h8000_0003};
    for (int i = 0; i < 8; i++) begin
      pulse(4'(1 << (i % 4)));
      idle(2);
    end
    pulse(4'b0010);
    idle(2);
    pulse(4'b0010);
    idle(2);
    axi_read(4'hC, got); total++;
    if (got !== 32'h8) begin bad++; $display("FAIL ovf_level_full got=%h want 00000008", got); end
    axi_read(4'h0, got); total++;
    if (got !== 32'h8000_000F) begin bad++; $display("FAIL ovf_status got=%h want 8000000f", got); end
    axi_read(4'h8, got); total++;
    if (got !== 32'h8000_0000) begin bad++; $display("FAIL ovf_first_pop got=%h want 80000000", got); end
    idle(2);
    axi_read(4'hC, got); total++;
    if (got !== 32'h8) begin bad++; $display("FAIL ovf_level_refill got=%h want 00000008", got); end
    for (int i = 0; i < 7; i++) begin
      axi_read(4'h8, got); total++;
      if (got !== exp[i]) begin bad++; $display("FAIL ovf_drain%0d got=%h want %h", i, got, exp[i]); end
    end
    axi_read(4'h8, got); total++;
    if (got !== 32'h8000_0001) begin bad++; $display("FAIL ovf_last_entry got=%h want 80000001", got); end
    axi_read(4'hC, got); total++;
    if (got !== 32'h0) begin bad++; $display("FAIL ovf_level_empty got=%h want 00000000", got); end
    // Strobe on the wrong bytes must not clear the low key bits
    axi_write(4'h0, 32'h0000_000F, 4'b1110, 4'b0);
    axi_write(4'h0, 32'h8000_0000, 4'b1000, 4'b0);
    axi_read(4'h0, got); total++;
    if (got !== 32'h0000_000F) begin bad++; $display("FAIL ovf_w1c got=%h want 0000000f", got); end
    axi_write(4'h0, 32'h8000_000F, 4'hF, 4'b0);
  endtask

  task automatic test_flush();
    logic [31:0] got;
    pulse(4'b0111);
    idle(5);
    axi_read(4'hC, got); total++;
    if (got !== 32'h3) begin bad++; $display("FAIL flush_level_before got=%h want 00000003", got); end
    axi_write(4'hC, 32'h1, 4'hF, 4'b0);
    axi_read(4'hC, got); total++;
    if (got !== 32'h0) begin bad++; $display("FAIL flush_level_after got=%h want 00000000", got); end
    axi_read(4'h8, got); total++;
    if (got !== 32'h0) begin bad++; $display("FAIL flush_event got=%h want 00000000", got); end
    axi_read(4'h0, got); total++;
    if (got !== 32'h7) begin bad++; $display("FAIL flush_status_kept got=%h want 00000007", got); end
    axi_write(4'h0, 32'h8000_000F, 4'hF, 4'b0);
  endtask

  task automatic test_irq();
    logic [31:0] got;
    axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 4'b0);
    axi_read(4'h4, got); total++;
    if (got !== 32'hF) begin bad++; $display("FAIL irqen_mask_bits got=%h want 0000000f", got); end
    axi_write(4'h4, 32'h2, 4'hF, 4'b0);
    axi_read(4'h4, got); total++;
    if (got !== 32'h2) begin bad++; $display("FAIL irqen_readback got=%h want 00000002", got); end
    pulse(4'b0001);
    idle(3);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked_key got=%b want 0", irq); end
    axi_write(4'h0, 32'hF, 4'hF, 4'b0);
    pulse(4'b0010);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_t1 got=%b want 0", irq); end
    idle(1);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_t2 got=%b want 1", irq); end
    axi_write(4'h0, 32'h2, 4'hF, 4'b0010);
    idle(2);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins got=%b want 1", irq); end
    axi_read(4'h0, got); total++;
    if (got !== 32'h2) begin bad++; $display("FAIL irq_status_kept got=%h want 00000002", got); end
    axi_write(4'h0, 32'h2, 4'hF, 4'b0);
    idle(2);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_cleared got=%b want 0", irq); end
    axi_write(4'hC, 32'h1, 4'hF, 4'b0);
    axi_write(4'h0, 32'h8000_000F, 4'hF, 4'b0);
  endtask

`ifdef AXI_KEY_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] diff;
    pulse(4'b0001);
    idle(99);
    pulse(4'b0010);
    idle(3);
    axi_read(4'h8, a);
    axi_read(4'h8, b);
    diff = b[23:8] - a[23:8];
    total++;
    if (diff !== 16'd100) begin bad++; $display("FAIL ts_delta got=%0d want 100", diff); end
    axi_write(4'h0, 32'h8000_000F, 4'hF, 4'b0);
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    pulse_key   = 4'b0;
    bus.awaddr  = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
    bus.araddr  = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_multi();
    test_overflow();
    test_flush();
    test_irq();
`ifdef AXI_KEY_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
